// File: rtl/icache_nway.sv
`default_nettype none
// ==================================================================
// icache_nway : N-way set-associative instruction cache, PLRU refill
// Rev 1.0
// ==================================================================
module icache_nway #(
  parameter int WAYS  = 2,
  parameter int SETS  = 64,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        Icache_en,
  input  logic        flush,
  input  logic [31:0] DataIn,
  input  logic        ready,
  output logic [31:0] DataOut,
  output logic        hit,
  output logic        Istall,
  output logic        IM_enable,
  output logic [31:0] IM_address,
  output logic [63:0] L1I_access,
  output logic [63:0] L1I_miss
);
  localparam int OB = 2 + $clog2(WORDS);
  localparam int IB = $clog2(SETS);
  localparam int TB = 32 - OB - IB;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REFILL = 2'd1, DONE = 2'd2} state_t;
  state_t state_q, state_d;

  logic [SETS-1:0] valid_q [WAYS];
  logic [2:0]      plru_q  [SETS];
  logic [TB-1:0]   tag_q   [WAYS][SETS];
  logic [31:0]     data_q  [WAYS][SETS][WORDS];

  logic [31:0]   base_q;
  logic [IB-1:0] set_q;
  logic [WW-1:0] victim_q;
  logic [KW-1:0] k_q, off_q;
  logic          fpend_q;
  logic [63:0]   access_q, miss_q;

  logic [IB-1:0] idx;
  logic [TB-1:0] tag_in;
  logic [KW-1:0] off;
  logic          hit_any, inv_any, last;
  logic [WW-1:0] hit_way, inv_way, vict;

  // Tree PLRU: b0 picks the half, b1/b2 pick within the half
  function automatic logic [2:0] plru_upd(input logic [2:0] b, input logic [1:0] w);
    plru_upd = b;
    if (WAYS == 4) begin
      plru_upd[0] = ~w[1];
      if (!w[1]) plru_upd[1] = ~w[0];
      else       plru_upd[2] = ~w[0];
    end else if (WAYS == 2) begin
      plru_upd[0] = ~w[0];
    end
  endfunction

  function automatic logic [1:0] plru_vict(input logic [2:0] b);
    if (WAYS == 4)      plru_vict = {b[0], b[0] ? b[2] : b[1]};
    else if (WAYS == 2) plru_vict = {1'b0, b[0]};
    else                plru_vict = 2'b00;
  endfunction

  assign idx        = address[OB+IB-1:OB];
  assign tag_in     = address[31:OB+IB];
  assign off        = KW'(address[OB-1:0] >> 2);
  assign last       = (k_q == KW'(WORDS - 1));
  assign L1I_access = access_q;
  assign L1I_miss   = miss_q;

  // Descending scan so the lowest-numbered matching/invalid way wins
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == tag_in)) begin
        hit_any = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[w][idx]) begin
        inv_any = 1'b1;
        inv_way = WW'(w);
      end
    end
    vict = inv_any ? inv_way : WW'(plru_vict(plru_q[idx]));
  end

  always_comb begin
    state_d    = state_q;
    DataOut    = '0;
    hit        = 1'b0;
    Istall     = 1'b0;
    IM_enable  = 1'b0;
    IM_address = '0;
    case (state_q)
      IDLE: begin
        if (Icache_en) begin
          if (hit_any) begin
            hit     = 1'b1;
            DataOut = data_q[hit_way][idx][off];
          end else begin
            Istall  = 1'b1;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        Istall     = 1'b1;
        IM_enable  = 1'b1;
        IM_address = base_q + 32'({k_q, 2'b00});
        if (ready && last) state_d = DONE;
      end
      DONE: begin
        DataOut = data_q[victim_q][set_q][off_q];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs must read as idle the instant reset is asserted
    if (!rst) begin
      DataOut = '0;
      hit     = 1'b0;
      Istall  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
      base_q   <= '0;
      set_q    <= '0;
      victim_q <= '0;
      k_q      <= '0;
      off_q    <= '0;
      fpend_q  <= 1'b0;
      access_q <= '0;
      miss_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (Icache_en) begin
            access_q <= access_q + 64'd1;
            if (hit_any) begin
              plru_q[idx] <= plru_upd(plru_q[idx], 2'(hit_way));
            end else begin
              miss_q   <= miss_q + 64'd1;
              base_q   <= {address[31:OB], {OB{1'b0}}};
              set_q    <= idx;
              victim_q <= vict;
              off_q    <= off;
              k_q      <= '0;
              fpend_q  <= 1'b0;
            end
          end
          if (flush) for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
        end
        REFILL: begin
          if (flush) begin
            fpend_q <= 1'b1;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
          end
          if (ready) begin
            k_q <= k_q + KW'(1);
            if (last) begin
              if (!(fpend_q || flush)) valid_q[victim_q][set_q] <= 1'b1;
              plru_q[set_q] <= plru_upd(plru_q[set_q], 2'(victim_q));
            end
          end
        end
        DONE: begin
          if (flush) for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == REFILL) && ready) begin
      data_q[victim_q][set_q][k_q] <= DataIn;
      if (last) tag_q[victim_q][set_q] <= base_q[31:OB+IB];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_nway.sv
`default_nettype none
// tb_icache_nway : directed and randomized checks of icache_nway against a line-level model.
module tb_icache_nway;
  localparam int WAYS  = 2;
  localparam int SETS  = 16;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address = '0;
  logic        Icache_en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] DataIn = '0;
  logic        ready = 1'b0;
  logic [31:0] DataOut;
  logic        hit, Istall, IM_enable;
  logic [31:0] IM_address;
  logic [63:0] L1I_access, L1I_miss;

  icache_nway #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .address(address), .Icache_en(Icache_en), .flush(flush),
    .DataIn(DataIn), .ready(ready), .DataOut(DataOut), .hit(hit), .Istall(Istall),
    .IM_enable(IM_enable), .IM_address(IM_address), .L1I_access(L1I_access), .L1I_miss(L1I_miss)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line-level model: a line is identified by its base address; m_vict is the way to replace next
  bit              m_valid [WAYS][SETS];
  logic [31:0]     m_line_of [WAYS][SETS];
  logic [31:0]     m_data  [WAYS][SETS][WORDS];
  int              m_vict  [SETS];
  int              m_state;   // 0 lookup, 1 refilling, 2 refill done
  int              m_k, m_set, m_way, m_off;
  logic [31:0]     m_line;
  bit              m_fl;
  longint unsigned m_acc, m_miss;
  int              cw;

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 4) % SETS);
  endfunction

  function automatic int m_lookup(input logic [31:0] a);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[w][set_of(a)] && m_line_of[w][set_of(a)] == (a & ~32'hF)) return w;
    return -1;
  endfunction

  function automatic void m_clear();
    for (int w = 0; w < WAYS; w++) for (int s = 0; s < SETS; s++) m_valid[w][s] = 1'b0;
  endfunction

  function automatic void m_reset();
    m_clear();
    for (int s = 0; s < SETS; s++) m_vict[s] = 0;
    m_state = 0;
    m_acc   = 0;
    m_miss  = 0;
  endfunction

  function automatic void m_step();
    int w;
    case (m_state)
      0: begin
        if (Icache_en) begin
          m_acc++;
          w = m_lookup(address);
          if (w >= 0) begin
            m_vict[set_of(address)] = 1 - w;
          end else begin
            m_miss++;
            m_line  = address & ~32'hF;
            m_set   = set_of(address);
            m_off   = int'((address >> 2) % WORDS);
            m_way   = m_vict[m_set];
            for (int v = WAYS - 1; v >= 0; v--) if (!m_valid[v][m_set]) m_way = v;
            m_k     = 0;
            m_fl    = 1'b0;
            m_state = 1;
          end
        end
        if (flush) m_clear();
      end
      1: begin
        if (flush) begin
          m_fl = 1'b1;
          m_clear();
        end
        if (ready) begin
          m_data[m_way][m_set][m_k] = DataIn;
          if (m_k == WORDS - 1) begin
            m_line_of[m_way][m_set] = m_line;
            if (!m_fl) m_valid[m_way][m_set] = 1'b1;
            m_vict[m_set] = 1 - m_way;
            m_state = 2;
          end
          m_k++;
        end
      end
      default: begin
        if (flush) m_clear();
        m_state = 0;
      end
    endcase
  endfunction

  always begin : compare
    @(negedge clk);
    if (!rst) begin
      m_reset();
      chk("rst_IM_enable", IM_enable, 0);
      chk("rst_IM_address", IM_address, 0);
      chk("rst_hit", hit, 0);
      chk("rst_Istall", Istall, 0);
      chk("rst_DataOut", DataOut, 0);
    end else begin
      case (m_state)
        0: begin
          chk("idle_IM_enable", IM_enable, 0);
          if (Icache_en) begin
            cw = m_lookup(address);
            if (cw >= 0) begin
              chk("idle_hit", hit, 1);
              chk("idle_Istall", Istall, 0);
              chk("idle_DataOut", DataOut, m_data[cw][set_of(address)][(address >> 2) % WORDS]);
            end else begin
              chk("idle_hit", hit, 0);
              chk("idle_Istall", Istall, 1);
            end
          end else begin
            chk("idle_hit", hit, 0);
            chk("idle_Istall", Istall, 0);
          end
        end
        1: begin
          chk("refill_hit", hit, 0);
          chk("refill_Istall", Istall, 1);
          chk("refill_IM_enable", IM_enable, 1);
          chk("refill_IM_address", IM_address, m_line + 32'(4 * m_k));
        end
        default: begin
          chk("done_hit", hit, 0);
          chk("done_Istall", Istall, 0);
          chk("done_IM_enable", IM_enable, 0);
          chk("done_DataOut", DataOut, m_data[m_way][m_set][m_off]);
        end
      endcase
    end
    chk("L1I_access", L1I_access, m_acc);
    chk("L1I_miss", L1I_miss, m_miss);
    @(posedge clk);
    if (rst) m_step();
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    DataIn = mem(IM_address);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    Icache_en = 1'b0;
    flush = 1'b0;
    ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] a, input int stall_k, input int stall_n,
                       input int flush_k, output bit was_hit);
    logic [31:0] base;
    base = a & ~32'hF;
    address = a;
    Icache_en = 1'b1;
    ready = 1'b0;
    flush = 1'b0;
    #2;
    was_hit = hit;
    if (was_hit) chk("hit_DataOut", DataOut, mem(a));
    else         chk("miss_Istall", Istall, 1);
    cyc();
    Icache_en = 1'b0;
    if (!was_hit) begin
      for (int k = 0; k < WORDS; k++) begin
        if (k == stall_k) begin
          for (int j = 0; j < stall_n; j++) begin
            ready = 1'b0;
            #2;
            chk("stall_IM_address", IM_address, base + 32'(4 * k));
            chk("stall_Istall", Istall, 1);
            cyc();
          end
        end
        ready = 1'b1;
        flush = (k == flush_k);
        #2;
        chk("word_IM_address", IM_address, base + 32'(4 * k));
        cyc();
      end
      ready = 1'b0;
      flush = 1'b0;
      #2;
      chk("done_word", DataOut, mem(a));
      chk("done_no_stall", Istall, 0);
      cyc();
    end
  endtask

  logic [31:0] pool [8] = '{32'h1000, 32'h2000, 32'h3000, 32'h1010,
                            32'h2014, 32'h1008, 32'h300C, 32'h4018};

  initial begin
    bit h;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Cold miss, then a hit on the same line
    fetch(32'h1000, -1, 0, -1, h);  chk("cold_miss", h, 0);
    fetch(32'h1008, -1, 0, -1, h);  chk("warm_hit", h, 1);
    chk("cold_access", L1I_access, 2);
    chk("cold_misses", L1I_miss, 1);

    // Replacement in set 0
    do_reset();
    fetch(32'h1000, -1, 0, -1, h);  chk("repl_a_miss", h, 0);
    fetch(32'h2000, -1, 0, -1, h);  chk("repl_b_miss", h, 0);
    fetch(32'h1000, -1, 0, -1, h);  chk("repl_a_hit", h, 1);
    fetch(32'h3000, -1, 0, -1, h);  chk("repl_c_miss", h, 0);
    fetch(32'h1000, -1, 0, -1, h);  chk("repl_a_kept", h, 1);
    fetch(32'h2000, -1, 0, -1, h);  chk("repl_b_evicted", h, 0);

    // Memory stall on word 1
    fetch(32'h1410, 1, 3, -1, h);   chk("stall_miss", h, 0);

    // Flush in IDLE, then flush during a refill
    fetch(32'h1000, -1, 0, -1, h);  chk("preflush_hit", h, 1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    fetch(32'h1000, -1, 0, -1, h);  chk("postflush_miss", h, 0);
    fetch(32'h1020, -1, 0, 2, h);   chk("midflush_fill_miss", h, 0);
    fetch(32'h1020, -1, 0, -1, h);  chk("midflush_line_invalid", h, 0);
    fetch(32'h1000, -1, 0, -1, h);  chk("midflush_other_invalid", h, 0);

    // Reset during word 2 of a refill
    do_reset();
    fetch(32'h1000, -1, 0, -1, h);
    address = 32'h2000;
    Icache_en = 1'b1;
    cyc();
    Icache_en = 1'b0;
    ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #2;
    chk("rst_mid_IM_enable", IM_enable, 0);
    chk("rst_mid_access", L1I_access, 0);
    chk("rst_mid_miss", L1I_miss, 0);
    cyc();
    rst = 1'b1;
    ready = 1'b0;
    fetch(32'h1000, -1, 0, -1, h);  chk("after_rst_miss", h, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      address   = pool[$urandom_range(0, 7)];
      Icache_en = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      ready     = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 299) != 0);
      DataIn    = $urandom();
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    Icache_en = 1'b0;
    flush = 1'b0;
    ready = 1'b1;
    repeat (8) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/icache_nway.md
ICACHE_NWAY -- requirements
Module: icache_nway

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity; legal 1, 2, 4.
REQ-002 SHALL have parameter SETS, default 64, sets per way; power of 2, at least 2.
REQ-003 SHALL have parameter WORDS, default 4, 32-bit words per line; power of 2, at least 1.
REQ-004 SHALL use derived fields: offset = address[OB-1:0] with OB = 2+log2(WORDS); index = next log2(SETS) bits; tag = remaining upper bits.
REQ-005 SHALL have ports:
- clk  in  1  clock, single domain
- rst  in  1  asynchronous, active-low reset
- address  in  32  fetch address, word aligned
- Icache_en  in  1  fetch request valid
- flush  in  1  invalidate all lines
- DataIn  in  32  refill word from instruction memory
- ready  in  1  memory accepted request; DataIn valid this cycle
- DataOut  out  32  fetched instruction
- hit  out  1  lookup hit this cycle
- Istall  out  1  fetch not served this cycle
- IM_enable  out  1  memory read request
- IM_address  out  32  memory word address
- L1I_access  out  64  lookup count
- L1I_miss  out  64  miss count

Function
REQ-006 SHALL hold per way and set: a valid bit, a tag, and WORDS data words. Arrays are flops; no SRAM macros.
REQ-007 SHALL run an FSM with states IDLE, REFILL and DONE.
REQ-008 In IDLE with Icache_en=1, lookup SHALL be combinational. hit=1 when a way has valid=1 and a matching tag. DataOut = that way's word[offset]. Istall=0.
REQ-009 In IDLE with Icache_en=1 and no hit, Istall=1 and hit=0 the same cycle; next state SHALL be REFILL.
REQ-010 On entry to REFILL, SHALL latch line base address, set index and victim way.
REQ-011 The victim SHALL be the lowest-index invalid way if any; otherwise the PLRU choice.
REQ-012 In REFILL: IM_enable=1, IM_address = line base + 4*k, k = 0..WORDS-1. Istall=1, hit=0.
- k advances only on a cycle with ready=1; that cycle DataIn is written to victim word k.
- IM_address SHALL be held stable while ready=0.
REQ-013 On the ready of word WORDS-1, SHALL write the tag, set valid=1 and update PLRU to the victim way; next state SHALL be DONE.
REQ-014 In DONE: DataOut = refilled word at the latched offset, Istall=0, hit=0, IM_enable=0. Next state SHALL be IDLE.
REQ-015 PLRU rules:
- WAYS=1: no state.
- WAYS=2: one bit per set; on access to way w, bit = ~w; victim = bit.
- WAYS=4: bits b0..b2 per set. On access to way w: b0 = ~w[1]; if w[1]=0 then b1 = ~w[0], else b2 = ~w[0]. Victim = {b0, b0 ? b2 : b1}.
REQ-016 Every hit in IDLE SHALL update the PLRU of the hit set.
REQ-017 L1I_access SHALL increment by 1 on each IDLE cycle with Icache_en=1. L1I_miss SHALL increment by 1 on each IDLE-to-REFILL transition. DONE cycles SHALL change neither counter. Both wrap modulo 2^64.
REQ-018 flush=1 in IDLE SHALL clear all valid bits at the clock edge. That cycle's lookup SHALL use pre-flush contents.
REQ-019 flush=1 during REFILL or DONE: the in-progress refill SHALL complete its memory transfer, but its line SHALL be left invalid and all other valid bits cleared.
REQ-020 With Icache_en=0 in IDLE: hit=0, Istall=0, no state or counter change.

Reset
REQ-021 rst=0 SHALL immediately force:
- FSM to IDLE; IM_enable=0; IM_address=0
- all valid bits and PLRU bits to 0
- L1I_access=0, L1I_miss=0
- DataOut=0, hit=0, Istall=0
REQ-022 Tags and data SHALL need no reset.
REQ-023 Reset during REFILL SHALL abandon the refill; the partially filled line SHALL be left invalid.

Verification (WAYS=2, SETS=16, WORDS=4)
REQ-024 Cold miss: fetch 0x1000 -> Istall=1; IM_address 0x1000, 0x1004, 0x1008, 0x100C, one per ready. DONE cycle gives DataOut = word 0. Then 0x1008 gives hit=1 in the same cycle. Access=2, miss=1.
REQ-025 Replacement: fill 0x1000 then 0x2000 (both set 0); hit 0x1000; miss 0x3000 -> evicts the 0x2000 way. 0x1000 then hits; 0x2000 misses.
REQ-026 Stall: ready held 0 for 3 cycles on word 1 -> IM_address stays 0x1004 and Istall=1 throughout.
REQ-027 Flush: after filling 0x1000, pulse flush in IDLE -> next 0x1000 fetch misses. Flush asserted mid-refill -> the refilled line misses afterwards.
REQ-028 Reset: assert rst=0 during word 2 of a refill -> IM_enable=0 at once, counters 0; after release, 0x1000 misses.
